// File: rtl/mag_cmp_pkg.sv
// mag_cmp_pkg: shared response record and id-width helper for the arbitrated comparator
package mag_cmp_pkg;
    localparam int MAX_IDW = 4;
    typedef struct packed {
        logic [MAX_IDW-1:0] id;
        logic               grt;
        logic               lst;
        logic               eql;
    } rsp_t;
    function automatic int idw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mag_cmp_base.sv
// mag_cmp_base: unsigned magnitude comparator, direct or borrow-based per IMPLEMENTATION
module mag_cmp_base #(
    parameter int WIDTH          = 32,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             grt,
    output logic             lst
);
    if (IMPLEMENTATION == 1) begin : g_sub
        logic [WIDTH:0] d;
        assign d   = {1'b0, a} - {1'b0, b};
        assign lst = d[WIDTH];
        assign grt = !d[WIDTH] && (|d[WIDTH-1:0]);
    end else begin : g_dir
        assign grt = a > b;
        assign lst = a < b;
    end
endmodule

// File: rtl/mag_cmp_arb.sv
// mag_cmp_arb: round-robin arbitrated shared magnitude comparator; MAG_CMP_ARB_EQL_EN adds rsp_eql
module mag_cmp_arb
    import mag_cmp_pkg::*;
#(
    parameter int  WIDTH          = 32,
    parameter int  REQN           = 4,
    parameter int  IMPLEMENTATION = 0,
    localparam int IDW            = idw(REQN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQN-1:0]            req_vld,
    input  logic [REQN-1:0][WIDTH-1:0] req_val,
    input  logic [REQN-1:0][WIDTH-1:0] req_rfr,
    output logic [REQN-1:0]            req_rdy,
    output logic                       rsp_vld,
    input  logic                       rsp_rdy,
    output logic [IDW-1:0]             rsp_id,
    output logic                       rsp_grt,
    output logic                       rsp_lst
`ifdef MAG_CMP_ARB_EQL_EN
    ,
    output logic                       rsp_eql
`endif
);
    logic [IDW-1:0] ptr, gnt_id;
    logic [IDW:0]   j;
    logic           hit, load, hs, cmp_grt, cmp_lst;
    rsp_t           r, nxt;
    logic           unused;

    // Rotating priority search starting at ptr.
    always_comb begin
        gnt_id = '0;
        hit    = 1'b0;
        j      = '0;
        for (int k = 0; k < REQN; k++) begin
            j = {1'b0, ptr} + (IDW+1)'(k);
            if (j >= (IDW+1)'(REQN)) j = j - (IDW+1)'(REQN);
            if (!hit && req_vld[j[IDW-1:0]]) begin
                hit    = 1'b1;
                gnt_id = j[IDW-1:0];
            end
        end
    end

    assign load    = !rsp_vld || rsp_rdy;
    assign req_rdy = (!rst && load && hit) ? (REQN'(1) << gnt_id) : '0;
    assign hs      = |req_rdy;

    mag_cmp_base #(
        .WIDTH          (WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_cmp (
        .a   (req_val[gnt_id]),
        .b   (req_rfr[gnt_id]),
        .grt (cmp_grt),
        .lst (cmp_lst)
    );

    always_comb begin
        nxt     = '0;
        nxt.id  = MAX_IDW'(gnt_id);
        nxt.grt = cmp_grt;
        nxt.lst = cmp_lst;
`ifdef MAG_CMP_ARB_EQL_EN
        nxt.eql = !(cmp_grt || cmp_lst);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r       <= '0;
            rsp_vld <= 1'b0;
            ptr     <= '0;
        end else if (hs) begin
            r       <= nxt;
            rsp_vld <= 1'b1;
            ptr     <= (gnt_id == IDW'(REQN-1)) ? '0 : gnt_id + 1'b1;
        end else if (rsp_rdy) begin
            rsp_vld <= 1'b0;
        end
    end

    assign rsp_id  = r.id[IDW-1:0];
    assign rsp_grt = r.grt;
    assign rsp_lst = r.lst;
`ifdef MAG_CMP_ARB_EQL_EN
    assign rsp_eql = r.eql;
`endif
    assign unused  = ^r;
endmodule

// File: tb/tb_mag_cmp_arb.sv
// tb_mag_cmp_arb: directed self-checking bench for mag_cmp_arb (WIDTH=32, REQN=4)
module tb_mag_cmp_arb;
    localparam int W = 32;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_vld = '1;
    logic [N-1:0][W-1:0] req_val = '0;
    logic [N-1:0][W-1:0] req_rfr = '0;
    logic [N-1:0]      req_rdy;
    logic              rsp_vld;
    logic              rsp_rdy = 1'b1;
    logic [1:0]        rsp_id;
    logic              rsp_grt;
    logic              rsp_lst;
`ifdef MAG_CMP_ARB_EQL_EN
    logic              rsp_eql;
`endif
    int checks = 0;
    int errors = 0;

    mag_cmp_arb #(.WIDTH(W), .REQN(N), .IMPLEMENTATION(0)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_val (req_val),
        .req_rfr (req_rfr),
        .req_rdy (req_rdy),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rsp_id  (rsp_id),
        .rsp_grt (rsp_grt),
`ifdef MAG_CMP_ARB_EQL_EN
        .rsp_lst (rsp_lst),
        .rsp_eql (rsp_eql)
`else
        .rsp_lst (rsp_lst)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                           input logic g, input logic l, input logic e);
        chk({tag, "_vld"}, 32'(rsp_vld), 32'(v));
        chk({tag, "_id"},  32'(rsp_id),  32'(id));
        chk({tag, "_grt"}, 32'(rsp_grt), 32'(g));
        chk({tag, "_lst"}, 32'(rsp_lst), 32'(l));
`ifdef MAG_CMP_ARB_EQL_EN
        chk({tag, "_eql"}, 32'(rsp_eql), 32'(e));
`else
        if (e === 1'bx) chk({tag, "_eqlarg"}, 32'(e), 32'(0));
`endif
    endtask

    logic [1:0] seq_id  [5] = '{0, 1, 2, 3, 0};
    logic       seq_grt [5] = '{0, 0, 1, 0, 0};
    logic       seq_lst [5] = '{1, 0, 0, 1, 1};
    logic       seq_eql [5] = '{0, 1, 0, 0, 0};

    initial begin
        // reset held two cycles with every requester active
        #1;
        chk("rst_rdy0", 32'(req_rdy), 32'(0));
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_rdy", 32'(req_rdy), 32'(0));
            chk("rst_vld", 32'(rsp_vld), 32'(0));
        end
        // single request from requester 0
        rst = 1'b0;
        req_vld = 4'b0001;
        req_val[0] = 32'd5;
        req_rfr[0] = 32'd3;
        #1;
        chk("single_rdy", 32'(req_rdy), 32'b0001);
        tick();
        chk_rsp("single", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
        req_vld = 4'b0000;
        #1;
        chk("idle_rdy", 32'(req_rdy), 32'(0));
        tick();
        chk("drain_vld", 32'(rsp_vld), 32'(0));
        // all-ones equal operands on requester 3, moves ptr back to 0
        req_vld = 4'b1000;
        req_val[3] = 32'hFFFF_FFFF;
        req_rfr[3] = 32'hFFFF_FFFF;
        #1;
        chk("max_rdy", 32'(req_rdy), 32'b1000);
        tick();
        chk_rsp("max_eq", 1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        // all four requesting, full throughput
        req_val[0] = 32'd10; req_rfr[0] = 32'd20;
        req_val[1] = 32'd7;  req_rfr[1] = 32'd7;
        req_val[2] = 32'd9;  req_rfr[2] = 32'd1;
        req_val[3] = 32'd0;  req_rfr[3] = 32'hFFFF_FFFF;
        req_vld = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("rr_rdy", 32'(req_rdy), 32'(1) << seq_id[s]);
            tick();
            chk_rsp("rr", 1'b1, seq_id[s], seq_grt[s], seq_lst[s], seq_eql[s]);
        end
        // backpressure while full
        rsp_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_rdy", 32'(req_rdy), 32'(0));
            tick();
            chk_rsp("bp_hold", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        end
        rsp_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(req_rdy), 32'b0010);
        tick();
        chk_rsp("bp_next", 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        // advance ptr to 3, then wrap with 1001
        req_vld = 4'b0100;
        tick();
        chk_rsp("to3", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        req_vld = 4'b1001;
        #1;
        chk("wrap_rdy3", 32'(req_rdy), 32'b1000);
        tick();
        chk_rsp("wrap3", 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
        #1;
        chk("wrap_rdy0", 32'(req_rdy), 32'b0001);
        tick();
        chk_rsp("wrap0", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        // reset with a pending response and active requests
        req_vld = 4'b1111;
        rst = 1'b1;
        #1;
        chk("rst2_rdy", 32'(req_rdy), 32'(0));
        tick();
        chk_rsp("rst2", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst2_ptr0", 32'(req_rdy), 32'b0001);
        tick();
        chk_rsp("post_rst", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
